// File: rtl/data_mem_arb.sv
// rtl/data_mem_arb.sv - two-port data memory arbiter with sub-word store merging
//
// Purpose:
//    Shares one single-ported, word-addressed data memory between a CPU
//    load/store port (p0) and a debug/loader port (p1). One memory access
//    per cycle. Byte and half stores from p0 are done as a read followed by
//    a merged word write (IDLE -> MERGE -> IDLE).
//
// Ports:
//    clk, rst                       clock, asynchronous active-high reset
//    p0_req/we/size/addr/wdata      CPU request (size 00 byte, 01 half, 1x word)
//    p0_gnt, p0_rvalid, p0_rdata    CPU grant and load return (full word)
//    p1_req/we/addr/wdata           debug request, word-only
//    p1_gnt, p1_rvalid, p1_rdata    debug grant and read return
//    mem_we, mem_a, mem_wd          memory command (byte address, word data)
//    mem_rd                         memory read data, one cycle after the read

module data_mem_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [1:0]  p0_size,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   // prio: 0 = p0 wins a tie, 1 = p1 wins a tie
   logic        prio;
   logic        prio_next;

   logic        rv0_q;
   logic        rv1_q;
   logic        rv0_next;
   logic        rv1_next;

   // Captured sub-word store, replayed in MERGE against the returned word
   logic [31:0] lat_addr;
   logic [15:0] lat_data;
   logic        lat_half;
   logic        lat_load;

   logic [31:0] merged;

   // Replace only the addressed lane of the word read during the grant cycle.
   always_comb begin
      merged = mem_rd;
      if (lat_half) begin
         if (lat_addr[1]) merged[31:16] = lat_data;
         else             merged[15:0]  = lat_data;
      end else begin
         case (lat_addr[1:0])
            2'd0:    merged[7:0]   = lat_data[7:0];
            2'd1:    merged[15:8]  = lat_data[7:0];
            2'd2:    merged[23:16] = lat_data[7:0];
            default: merged[31:24] = lat_data[7:0];
         endcase
      end
   end

   // Next state, grants and memory command. rst gates every output so that
   // an asynchronous reset in MERGE drops the pending write immediately.
   always_comb begin
      state_next = state;
      prio_next  = prio;
      p0_gnt     = 1'b0;
      p1_gnt     = 1'b0;
      mem_we     = 1'b0;
      mem_a      = 32'h0;
      mem_wd     = 32'h0;
      rv0_next   = 1'b0;
      rv1_next   = 1'b0;
      lat_load   = 1'b0;

      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (p0_req && (!p1_req || !prio)) begin
                  p0_gnt    = 1'b1;
                  prio_next = 1'b1;
                  mem_a     = p0_addr;
                  mem_wd    = p0_wdata;
                  if (!p0_we) begin
                     rv0_next = 1'b1;
                  end else if (p0_size[1]) begin
                     mem_we = 1'b1;
                  end else begin
                     // sub-word store: this cycle is the read half of the RMW
                     lat_load   = 1'b1;
                     state_next = ST_MERGE;
                  end
               end else if (p1_req) begin
                  p1_gnt    = 1'b1;
                  prio_next = 1'b0;
                  mem_a     = p1_addr;
                  mem_wd    = p1_wdata;
                  mem_we    = p1_we;
                  rv1_next  = !p1_we;
               end
            end
            ST_MERGE: begin
               mem_we     = 1'b1;
               mem_a      = lat_addr;
               mem_wd     = merged;
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         prio     <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         lat_addr <= 32'h0;
         lat_data <= 16'h0;
         lat_half <= 1'b0;
      end else begin
         state <= state_next;
         prio  <= prio_next;
         rv0_q <= rv0_next;
         rv1_q <= rv1_next;
         if (lat_load) begin
            lat_addr <= p0_addr;
            lat_data <= p0_wdata[15:0];
            lat_half <= p0_size[0];
         end
      end
   end

   assign p0_rvalid = rv0_q;
   assign p1_rvalid = rv1_q;
   assign p0_rdata  = rv0_q ? mem_rd : 32'h0;
   assign p1_rdata  = rv1_q ? mem_rd : 32'h0;

endmodule

// File: tb/tb_data_mem_arb.sv
// tb/tb_data_mem_arb.sv - self-checking bench for data_mem_arb

module tb_data_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we;
   logic [1:0]  p0_size;
   logic [31:0] p0_addr, p0_wdata;
   logic        p0_gnt, p0_rvalid;
   logic [31:0] p0_rdata;
   logic        p1_req, p1_we;
   logic [31:0] p1_addr, p1_wdata;
   logic        p1_gnt, p1_rvalid;
   logic [31:0] p1_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   int checks = 0;
   int fails  = 0;

   logic [31:0] ram [256] = '{default: 32'h0};
   logic [31:0] ref_mem [256] = '{default: 32'h0};

   always #5 clk = ~clk;

   data_mem_arb dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Registered-read memory, word index from byte address
   always @(posedge clk) begin
      if (mem_we) ram[mem_a[9:2]] <= mem_wd;
      mem_rd <= ram[mem_a[9:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [1:0] s0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      p0_req = r0; p0_we = w0; p0_size = s0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
   endtask

   task automatic idle();
      drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic        p0r, p0w;
      logic [1:0]  p0s;
      logic [31:0] p0a, p0d;
      logic        p1r, p1w;
      logic [31:0] p1a, p1d;
      logic        g0, g1, we;
      logic [31:0] a, wd;
      logic        rv0;
      logic [31:0] rd0;
      logic        rv1;
      logic [31:0] rd1;
   } vec_t;

   vec_t vt [19];

   function automatic vec_t mk(
      logic p0r, logic p0w, logic [1:0] p0s, logic [31:0] p0a, logic [31:0] p0d,
      logic p1r, logic p1w, logic [31:0] p1a, logic [31:0] p1d,
      logic g0, logic g1, logic we, logic [31:0] a, logic [31:0] wd,
      logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1);
      vec_t v;
      v.p0r = p0r; v.p0w = p0w; v.p0s = p0s; v.p0a = p0a; v.p0d = p0d;
      v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
      v.g0 = g0; v.g1 = g1; v.we = we; v.a = a; v.wd = wd;
      v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
      return v;
   endfunction

   // model state for the random run
   logic        m_prio, m_stall;
   logic        cur_rv0, cur_rv1, nxt_rv0, nxt_rv1, eg0, eg1;
   logic [31:0] cur_rd0, cur_rd1, nxt_rd0, nxt_rd1;

   initial begin
      rst = 1'b1;
      drive(1, 0, 2'd2, 32'h100, 0, 1, 0, 32'h104, 0);
      #2;
      chk("rst_gnt0", p0_gnt, 0);
      chk("rst_gnt1", p1_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      @(negedge clk);
      chk("rst_rvalid0", p0_rvalid, 0);
      chk("rst_rvalid1", p1_rvalid, 0);
      chk("rst_rdata0", p0_rdata, 0);
      idle();
      @(negedge clk);
      rst = 1'b0;

      // directed table
      vt[0]  = mk(0,0,2'd0,0,0,               1,1,32'h100,32'hAABBCCDD, 0,1,1,32'h100,32'hAABBCCDD, 0,0,0,0);
      vt[1]  = mk(1,0,2'd2,32'h100,0,         0,0,0,0,                  1,0,0,32'h100,0,            0,0,0,0);
      vt[2]  = mk(0,0,2'd0,0,0,               0,0,0,0,                  0,0,0,0,0,                  1,32'hAABBCCDD,0,0);
      vt[3]  = mk(1,1,2'd0,32'h102,32'h11,    0,0,0,0,                  1,0,0,32'h102,0,            0,0,0,0);
      vt[4]  = mk(1,0,2'd2,32'h100,0,         1,0,32'h100,0,            0,0,1,32'h102,32'hAA11CCDD, 0,0,0,0);
      vt[5]  = mk(1,0,2'd2,32'h100,0,         1,0,32'h100,0,            0,1,0,32'h100,0,            0,0,0,0);
      vt[6]  = mk(1,0,2'd2,32'h100,0,         0,0,0,0,                  1,0,0,32'h100,0,            0,0,1,32'hAA11CCDD);
      vt[7]  = mk(0,0,2'd0,0,0,               0,0,0,0,                  0,0,0,0,0,                  1,32'hAA11CCDD,0,0);
      vt[8]  = mk(0,0,2'd0,0,0,               1,1,32'h200,32'h11223344, 0,1,1,32'h200,32'h11223344, 0,0,0,0);
      vt[9]  = mk(1,1,2'd1,32'h203,32'h5566,  0,0,0,0,                  1,0,0,32'h203,0,            0,0,0,0);
      vt[10] = mk(0,0,2'd0,0,0,               1,0,32'h200,0,            0,0,1,32'h203,32'h55663344, 0,0,0,0);
      vt[11] = mk(0,0,2'd0,0,0,               1,0,32'h200,0,            0,1,0,32'h200,0,            0,0,0,0);
      vt[12] = mk(0,0,2'd0,0,0,               0,0,0,0,                  0,0,0,0,0,                  0,0,1,32'h55663344);
      vt[13] = mk(1,1,2'd2,32'h300,32'hDEADBEEF, 0,0,0,0,               1,0,1,32'h300,32'hDEADBEEF, 0,0,0,0);
      vt[14] = mk(1,0,2'd2,32'h300,0,         0,0,0,0,                  1,0,0,32'h300,0,            0,0,0,0);
      vt[15] = mk(0,0,2'd0,0,0,               0,0,0,0,                  0,0,0,0,0,                  1,32'hDEADBEEF,0,0);
      vt[16] = mk(1,1,2'd3,32'h304,32'h12345678, 0,0,0,0,               1,0,1,32'h304,32'h12345678, 0,0,0,0);
      vt[17] = mk(0,0,2'd0,0,0,               1,0,32'h304,0,            0,1,0,32'h304,0,            0,0,0,0);
      vt[18] = mk(0,0,2'd0,0,0,               0,0,0,0,                  0,0,0,0,0,                  0,0,1,32'h12345678);

      for (int i = 0; i < 19; i++) begin
         @(posedge clk); #1;
         drive(vt[i].p0r, vt[i].p0w, vt[i].p0s, vt[i].p0a, vt[i].p0d,
               vt[i].p1r, vt[i].p1w, vt[i].p1a, vt[i].p1d);
         @(negedge clk);
         chk($sformatf("row%0d_gnt0", i), p0_gnt, vt[i].g0);
         chk($sformatf("row%0d_gnt1", i), p1_gnt, vt[i].g1);
         chk($sformatf("row%0d_mem_we", i), mem_we, vt[i].we);
         chk($sformatf("row%0d_mem_a", i), mem_a, vt[i].a);
         if (vt[i].we) chk($sformatf("row%0d_mem_wd", i), mem_wd, vt[i].wd);
         chk($sformatf("row%0d_rvalid0", i), p0_rvalid, vt[i].rv0);
         chk($sformatf("row%0d_rdata0", i), p0_rdata, vt[i].rd0);
         chk($sformatf("row%0d_rvalid1", i), p1_rvalid, vt[i].rv1);
         chk($sformatf("row%0d_rdata1", i), p1_rdata, vt[i].rd1);
      end

      // both ports requesting continuously from reset: grants alternate
      reset_pulse();
      drive(1, 0, 2'd2, 32'h0, 0, 1, 0, 32'h4, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("alt%0d_gnt0", i), p0_gnt, (i % 2 == 0));
         chk($sformatf("alt%0d_gnt1", i), p1_gnt, (i % 2 == 1));
         @(posedge clk); #1;
      end

      // reset during MERGE aborts the write
      idle();
      @(posedge clk); #1;
      drive(0, 0, 2'd0, 0, 0, 1, 1, 32'h3F0, 32'h11223344);
      @(posedge clk); #1;
      drive(1, 1, 2'd0, 32'h3F1, 32'hFF, 0, 0, 0, 0);
      @(negedge clk);
      chk("rmwabort_grant", p0_gnt, 1);
      @(posedge clk); #1;
      idle();
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rmwabort_mem_we", mem_we, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rmwabort_word", ram[8'hFC], 32'h11223344);

      // reset with a read in flight suppresses rvalid
      @(posedge clk); #1;
      drive(0, 0, 2'd0, 0, 0, 1, 0, 32'h3F0, 0);
      @(posedge clk); #1;
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("rdabort_rvalid1", p1_rvalid, 0);
      chk("rdabort_rdata1", p1_rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // randomized run against a word-level model
      reset_pulse();
      m_prio = 1'b0; m_stall = 1'b0;
      nxt_rv0 = 1'b0; nxt_rv1 = 1'b0; nxt_rd0 = 0; nxt_rd1 = 0;
      for (int c = 0; c < 400; c++) begin
         logic        r0, w0, r1, w1;
         logic [1:0]  s0;
         logic [31:0] a0, d0, a1, d1;
         logic [7:0]  wi;
         int          sh;
         logic [31:0] msk;
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 2) == 0);
         w0 = $urandom_range(0, 1);
         w1 = $urandom_range(0, 1);
         s0 = 2'($urandom_range(0, 3));
         a0 = 32'($urandom_range(0, 63));
         a1 = 32'($urandom_range(0, 15)) * 4;
         d0 = $urandom;
         d1 = $urandom;
         @(posedge clk); #1;
         drive(r0, w0, s0, a0, d0, r1, w1, a1, d1);

         cur_rv0 = nxt_rv0; cur_rd0 = nxt_rd0;
         cur_rv1 = nxt_rv1; cur_rd1 = nxt_rd1;
         nxt_rv0 = 1'b0; nxt_rv1 = 1'b0;
         eg0 = 1'b0; eg1 = 1'b0;
         if (m_stall) begin
            m_stall = 1'b0;
         end else if (r0 && (!r1 || m_prio == 1'b0)) begin
            eg0 = 1'b1; m_prio = 1'b1;
            wi = a0[9:2];
            if (!w0) begin
               nxt_rv0 = 1'b1; nxt_rd0 = ref_mem[wi];
            end else if (s0 >= 2) begin
               ref_mem[wi] = d0;
            end else begin
               if (s0 == 0) begin sh = a0[1:0] * 8;  msk = 32'hFF   << sh; end
               else         begin sh = a0[1]   * 16; msk = 32'hFFFF << sh; end
               ref_mem[wi] = (ref_mem[wi] & ~msk) | ((d0 << sh) & msk);
               m_stall = 1'b1;
            end
         end else if (r1) begin
            eg1 = 1'b1; m_prio = 1'b0;
            wi = a1[9:2];
            if (!w1) begin
               nxt_rv1 = 1'b1; nxt_rd1 = ref_mem[wi];
            end else begin
               ref_mem[wi] = d1;
            end
         end

         @(negedge clk);
         chk($sformatf("rnd%0d_gnt0", c), p0_gnt, eg0);
         chk($sformatf("rnd%0d_gnt1", c), p1_gnt, eg1);
         chk($sformatf("rnd%0d_rvalid0", c), p0_rvalid, cur_rv0);
         chk($sformatf("rnd%0d_rdata0", c), p0_rdata, cur_rv0 ? cur_rd0 : 32'h0);
         chk($sformatf("rnd%0d_rvalid1", c), p1_rvalid, cur_rv1);
         chk($sformatf("rnd%0d_rdata1", c), p1_rdata, cur_rv1 ? cur_rd1 : 32'h0);
      end
      @(posedge clk); #1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 16; w++)
         chk($sformatf("rnd_mem%0d", w), ram[w], ref_mem[w]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
